// File: rtl/lfsr_share_pkg.sv
// Shared definitions for the shared-LFSR controller.
//   state_t    : controller FSM encoding (IDLE/RUN/RESP)
//   LFSR_W     : LFSR width (5)
//   TAP        : bit position that receives the feedback XOR
//   lfsr_step  : one advance of the 5-bit internal-XOR LFSR
package lfsr_share_pkg;

    localparam int LFSR_W = 5;
    localparam int TAP    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // s0'=s4, s1'=s0, s2'=s1^s4, s3'=s2, s4'=s3
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n      = {s[LFSR_W-2:0], s[LFSR_W-1]};
        n[TAP] = s[TAP-1] ^ s[LFSR_W-1];
        return n;
    endfunction

endpackage

// File: rtl/lfsr5_step_core.sv
// 5-bit internal-XOR LFSR register.
//   clk, rst  : clock, synchronous active-high reset (state <= SEED)
//   load      : load load_val (has priority over en)
//   load_val  : value to load
//   en        : advance one step
//   q         : current LFSR state
module lfsr5_step_core
    import lfsr_share_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 5'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)       q <= SEED;
        else if (load) q <= load_val;
        else if (en)   q <= lfsr_step(q);
    end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin controller sharing one 5-bit LFSR between NREQ requesters.
// One transaction at a time: grant, step the LFSR STEPS times, return the
// state with the requester index. Seeds load only while idle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req         : level requests, held until own rsp_valid
//   gnt         : one-hot grant held for the whole transaction
//   rsp_valid   : one-cycle response strobe; rsp_data / rsp_id hold otherwise
//   rsp_data    : LFSR state after STEPS advances
//   rsp_id      : index of the served requester
//   seed_we     : seed load strobe (only honoured when seed_ready)
//   seed_in     : seed value
//   seed_ready  : high only in IDLE
//   zero_err    : sticky all-zero detect
// Optional feature: define LFSR_SHARE_ZERO_GUARD_EN to reseed with SEED on
// a zero seed or a zero LFSR state; otherwise zero_err is tied low.
module lfsr_share_ctrl
    import lfsr_share_pkg::*;
#(
    parameter int                NREQ  = 4,
    parameter int                STEPS = 5,
    parameter logic [LFSR_W-1:0] SEED  = 5'h01,
    localparam int               IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [LFSR_W-1:0] rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              seed_ready,
    output logic              zero_err
);

    localparam int CW = $clog2(STEPS + 1);

    state_t            state;
    logic [IDW-1:0]    rr;
    logic [IDW-1:0]    cur;
    logic [CW-1:0]     cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] lfsr_val;
    logic              lfsr_load;
    logic              lfsr_en;
    logic              pick_any;
    logic [IDW-1:0]    pick_idx;

    assign seed_ready = (state == IDLE);

    // Round-robin pick: scan downward so the lowest offset from rr wins.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr) + k) % NREQ]) begin
                pick_any = 1'b1;
                pick_idx = IDW'((int'(rr) + k) % NREQ);
            end
        end
    end

`ifdef LFSR_SHARE_ZERO_GUARD_EN
    logic zero_fix;
    always_comb begin
        zero_fix = (state == IDLE && seed_we && seed_in == '0) ||
                   (((state == IDLE && !seed_we) || state == RUN) && lfsr == '0);
    end
`endif

    // LFSR control, plus a local copy of the value the core will hold
    // after this edge so the response captures the final step directly.
    always_comb begin
        lfsr_load = (state == IDLE) && seed_we;
        lfsr_val  = seed_in;
        lfsr_en   = (state == RUN);
`ifdef LFSR_SHARE_ZERO_GUARD_EN
        if (zero_fix) begin
            lfsr_load = 1'b1;
            lfsr_val  = SEED;
        end
`endif
        if (lfsr_load)    lfsr_nxt = lfsr_val;
        else if (lfsr_en) lfsr_nxt = lfsr_step(lfsr);
        else              lfsr_nxt = lfsr;
    end

    lfsr5_step_core #(.SEED(SEED)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_val),
        .en       (lfsr_en),
        .q        (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr        <= '0;
            cur       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a seed load blocks granting in the same cycle
                    if (!seed_we && pick_any) begin
                        gnt   <= NREQ'(1) << pick_idx;
                        cur   <= pick_idx;
                        cnt   <= CW'(STEPS);
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= lfsr_nxt;
                        rsp_id    <= cur;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    gnt       <= '0;
                    rr        <= (cur == IDW'(NREQ - 1)) ? '0 : cur + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LFSR_SHARE_ZERO_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst)           zero_err <= 1'b0;
        else if (zero_fix) zero_err <= 1'b1;
    end
`else
    assign zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Directed bench for lfsr_share_ctrl (NREQ=4, STEPS=5, SEED=5'h01).
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_lfsr_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rsp_valid;
    logic [4:0] rsp_data;
    logic [1:0] rsp_id;
    logic       seed_we;
    logic [4:0] seed_in;
    logic       seed_ready;
    logic       zero_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_share_ctrl #(.NREQ(4), .STEPS(5), .SEED(5'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .seed_we    (seed_we),
        .seed_in    (seed_in),
        .seed_ready (seed_ready),
        .zero_err   (zero_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until rsp_valid is seen; returns the number of ticks (bounded).
    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int         n;
        int         seen;
        logic [3:0] exp_g [5];
        logic [4:0] exp_d [5];
        logic [1:0] exp_i [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{5'h05, 5'h11, 5'h1F, 5'h0C, 5'h19};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1; req = '0; seed_we = 1'b0; seed_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 5'h00);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_seed_ready", seed_ready, 1'b1);
        chk("rst_zero_err", zero_err, 1'b0);

        // 1: single requester, latency and first value
        req = 4'b0001;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        wait_rsp(n);
        chk("t1_latency", n, 5);
        chk("t1_data", rsp_data, 5'h05);
        chk("t1_id", rsp_id, 2'd0);
        req = '0;
        tick();
        chk("t1_strobe_off", rsp_valid, 1'b0);
        chk("t1_gnt_off", gnt, 4'b0000);
        chk("t1_data_hold", rsp_data, 5'h05);

        // 2: all requesting, round-robin rotation and LFSR continuation
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                chk("t2_gap", gnt, 4'b0000);
            end
            tick();
            chk($sformatf("t2_gnt%0d", i), gnt, exp_g[i]);
            wait_rsp(n);
            chk($sformatf("t2_lat%0d", i), n, 5);
            chk($sformatf("t2_data%0d", i), rsp_data, exp_d[i]);
            chk($sformatf("t2_id%0d", i), rsp_id, exp_i[i]);
        end
        req = '0;
        tick();

        // 3: seed load wins over a simultaneous request
        seed_we = 1'b1; seed_in = 5'h01; req = 4'b0010;
        tick();
        seed_we = 1'b0;
        chk("t3_no_gnt", gnt, 4'b0000);
        tick();
        chk("t3_gnt", gnt, 4'b0010);
        wait_rsp(n);
        chk("t3_data", rsp_data, 5'h05);
        chk("t3_id", rsp_id, 2'd1);
        req = '0;
        tick();

        // 4: seed_we during RUN is ignored
        req = 4'b0100;
        tick();
        chk("t4_gnt", gnt, 4'b0100);
        chk("t4_ready_run", seed_ready, 1'b0);
        tick();
        seed_we = 1'b1; seed_in = 5'h1F;
        tick();
        seed_we = 1'b0;
        chk("t4_ready_run2", seed_ready, 1'b0);
        wait_rsp(n);
        chk("t4_latency", n, 3);
        chk("t4_ready_resp", seed_ready, 1'b0);
        chk("t4_data", rsp_data, 5'h11);
        chk("t4_id", rsp_id, 2'd2);
        req = '0;
        tick();
        chk("t4_ready_idle", seed_ready, 1'b1);

        // 5: zero seed
        seed_we = 1'b1; seed_in = 5'h00;
        tick();
        seed_we = 1'b0;
        req = 4'b1000;
        tick();
        chk("t5_gnt", gnt, 4'b1000);
        wait_rsp(n);
        chk("t5_id", rsp_id, 2'd3);
`ifdef LFSR_SHARE_ZERO_GUARD_EN
        chk("t5_data", rsp_data, 5'h05);
        chk("t5_zero_err", zero_err, 1'b1);
`else
        chk("t5_data", rsp_data, 5'h00);
        chk("t5_zero_err", zero_err, 1'b0);
`endif
        req = '0;
        tick();

        // 6: reset mid-RUN discards the transaction
        req = 4'b0001;
        tick();
        chk("t6_gnt", gnt, 4'b0001);
        tick(); tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        chk("t6_gnt_cleared", gnt, 4'b0000);
        chk("t6_rsp_data_rst", rsp_data, 5'h00);
        chk("t6_zero_err_rst", zero_err, 1'b0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) seen++;
            tick();
        end
        chk("t6_no_rsp", seen, 0);
        req = 4'b1000;
        tick();
        chk("t6_gnt2", gnt, 4'b1000);
        wait_rsp(n);
        chk("t6_latency", n, 5);
        chk("t6_data", rsp_data, 5'h05);
        chk("t6_id", rsp_id, 2'd3);
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
